// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter with a fixed clocks-per-bit divider and registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_byte #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_done,
  output logic       uart_txd,
  output logic       uart_tx_busy
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_next;
  logic        txd_next;
  logic        done_next;
  logic        busy_next;
  logic        bit_end;

  assign bit_end = (cnt == LAST);

  // State, counters and outputs all register together so the outputs line up with the state.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'd0;
      uart_txd     <= 1'b1;
      uart_tx_done <= 1'b0;
      uart_tx_busy <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      bit_idx      <= bit_idx_next;
      shift_reg    <= shift_next;
      uart_txd     <= txd_next;
      uart_tx_done <= done_next;
      uart_tx_busy <= busy_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = 16'd0;
    bit_idx_next = 3'd0;
    shift_next   = shift_reg;
    if (state != IDLE) begin
      cnt_next = bit_end ? 16'd0 : cnt + 16'd1;
    end
    case (state)
      IDLE: begin
        if (uart_tx_en) state_next = START;
      end
      START: begin
        // Data is captured at the end of the start bit, not at the request.
        if (bit_end) begin
          state_next = DATA;
          shift_next = uart_tx_data;
        end
      end
      DATA: begin
        bit_idx_next = bit_idx;
        if (bit_end) begin
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values match the state they belong to.
  always_comb begin
    txd_next  = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (cnt_next == LAST);
    case (state_next)
      START:  txd_next = 1'b0;
      DATA:   txd_next = shift_next[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_next = ^shift_next;
`endif
      default: txd_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte: CLK_DIV=8 instance for frame tests, default instance for timing.
// Expected line values come from a small frame model; parity expectations apply when UART_TX_PARITY_EN is defined.
module tb_uart_tx_byte;

  localparam int DIV = 8;
  localparam int DIV_L = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] data;
  logic       done;
  logic       txd;
  logic       busy;
  logic       en_l;
  logic [7:0] data_l;
  logic       done_l;
  logic       txd_l;
  logic       busy_l;

  int tests = 0;
  int failed = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  uart_tx_byte #(.CLK_DIV(DIV)) dut (
    .clk_50m      (clk),
    .rst          (rst),
    .uart_tx_en   (en),
    .uart_tx_data (data),
    .uart_tx_done (done),
    .uart_txd     (txd),
    .uart_tx_busy (busy)
  );

  uart_tx_byte dut_slow (
    .clk_50m      (clk),
    .rst          (rst),
    .uart_tx_en   (en_l),
    .uart_tx_data (data_l),
    .uart_tx_done (done_l),
    .uart_txd     (txd_l),
    .uart_tx_busy (busy_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level for frame bit k: start, 8 data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    else if (k == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  // Entered on the first START cycle; leaves on the idle cycle after done.
  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("%s_txd_b%0d_c%0d", tag, k, c), 32'(txd), 32'(frame_bit(b, k)));
        chk($sformatf("%s_busy_b%0d_c%0d", tag, k, c), 32'(busy), 32'd1);
        chk($sformatf("%s_done_b%0d_c%0d", tag, k, c), 32'(done),
            32'((k == NB - 1) && (c == DIV - 1)));
        step();
      end
    end
    chk({tag, "_idle_txd"}, 32'(txd), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] seq [10];
    int pulses0;
    int errs;
    seq = '{8'h99, 8'h24, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    rst = 1'b1; en = 1'b0; data = 8'h00; en_l = 1'b0; data_l = 8'h00;
    step();
    step();
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Reset wins over a simultaneous request.
    en = 1'b1;
    step();
    chk("rst_prio_busy", 32'(busy), 32'd0);
    chk("rst_prio_txd", 32'(txd), 32'd1);
    en = 1'b0; rst = 1'b0;
    step();
    step();
    chk("idle_hold_busy", 32'(busy), 32'd0);
    chk("idle_hold_txd", 32'(txd), 32'd1);

    // Single byte with a one-cycle request.
    data = 8'h99; en = 1'b1;
    step();
    en = 1'b0;
    check_frame(8'h99, "single");
    chk("single_pulses", 32'(done_pulses), 32'd1);

    // Data changes one cycle after the request.
    step();
    data = 8'h00; en = 1'b1;
    step();
    en = 1'b0; data = 8'h24;
    check_frame(8'h24, "late");

    // Back-to-back with the request held high.
    step();
    pulses0 = done_pulses;
    data = seq[0]; en = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) en = 1'b0;
      check_frame(seq[i], $sformatf("b2b%0d", i));
      if (i < 9) begin
        data = seq[i+1];
        step();
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("b2b_no11_busy%0d", i), 32'(busy), 32'd0);
    end
    chk("b2b_pulses", 32'(done_pulses - pulses0), 32'd10);

    // Reset during data bit 3 of 0xA5.
    data = 8'hA5; en = 1'b1;
    step();
    en = 1'b0;
    for (int c = 0; c < 35; c++) begin
      chk($sformatf("abort_txd_c%0d", c), 32'(txd), 32'(frame_bit(8'hA5, c / DIV)));
      step();
    end
    pulses0 = done_pulses;
    rst = 1'b1;
    step();
    chk("abort_txd", 32'(txd), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 90; i++) step();
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done_pulses - pulses0), 32'd0);
    en = 1'b1;
    step();
    en = 1'b0;
    check_frame(8'hA5, "after_abort");

`ifdef UART_TX_PARITY_EN
    // 0x07 carries parity 1, 0x03 parity 0; frames 89 cycles apart.
    step();
    data = 8'h07; en = 1'b1;
    step();
    check_frame(8'h07, "par07");
    data = 8'h03;
    step();
    en = 1'b0;
    check_frame(8'h03, "par03");
`endif

    // Default divider: 0x55 at 434 clocks per bit.
    step();
    data_l = 8'h55; en_l = 1'b1;
    step();
    en_l = 1'b0;
    for (int k = 0; k < NB; k++) begin
      errs = 0;
      for (int c = 0; c < DIV_L; c++) begin
        if (txd_l !== frame_bit(8'h55, k)) errs++;
        if (busy_l !== 1'b1) errs++;
        if ((k == NB - 1) && (c == DIV_L - 1))
          chk("slow_done_last", 32'(done_l), 32'd1);
        else if (done_l !== 1'b0)
          errs++;
        step();
      end
      chk($sformatf("slow_bit%0d_errs", k), 32'(errs), 32'd0);
    end
    chk("slow_idle_busy", 32'(busy_l), 32'd0);
    chk("slow_idle_txd", 32'(txd_l), 32'd1);
    chk("slow_idle_done", 32'(done_l), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
